// File: rtl/mem_word_loader_if.sv
// mem_word_loader_if
//   Bundles the control, byte-stream and memory-write signals of mem_word_loader.
//   master : controller/stream source/memory side (drives start, base_addr,
//            word_count, s_data, s_valid; observes everything else)
//   slave  : the loader itself
//   Signals:
//     start, base_addr[ADDR_W], word_count[ADDR_W+1]  load request
//     s_data[8], s_valid, s_ready                     byte stream
//     mem_we, mem_addr[ADDR_W], mem_data[32]          memory write port
//     busy, done, checksum[32]                        status
interface mem_word_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    modport master (
        output start, base_addr, word_count, s_data, s_valid,
        input  s_ready, mem_we, mem_addr, mem_data, busy, done, checksum
    );

    modport slave (
        input  start, base_addr, word_count, s_data, s_valid,
        output s_ready, mem_we, mem_addr, mem_data, busy, done, checksum
    );
endinterface

// File: rtl/mem_word_loader.sv
// mem_word_loader
//   Packs an 8-bit valid/ready byte stream into 32-bit words and writes them to
//   consecutive word addresses (wrapping modulo 2**ADDR_W) of the downstream
//   memory, one write per word. Reports busy/done and the XOR of all words
//   written during the current/last load.
//   Parameters:
//     ADDR_W  : memory address width (depth = 2**ADDR_W words)
//     BYTE_LE : 1 -> first byte lands in bits[7:0]; 0 -> first byte in bits[31:24]
//   Ports:
//     clk  : rising-edge clock shared with the memory
//     rst  : synchronous active-high reset
//     bus  : slave side of mem_word_loader_if (control, stream, memory, status)
module mem_word_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned BYTE_LE = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_word_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       checksum_q, checksum_d;

    logic [1:0]        lane;
    logic [31:0]       word_merged;
    logic              xfer;

    // Byte lane for the current byte; big-endian fills from the top lane down.
    always_comb begin
        lane        = (BYTE_LE != 0) ? byte_idx_q : ~byte_idx_q;
        word_merged = word_q;
        word_merged[{lane, 3'b000} +: 8] = bus.s_data;
    end

    assign xfer = bus.s_valid & s_ready_q;

    // Every output is a register; this block computes their next values so the
    // outputs change on the same edge as the state they belong to.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        s_ready_d  = s_ready_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE: begin
                s_ready_d = 1'b0;
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    count_d    = bus.word_count;
                    checksum_d = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    if (bus.word_count != '0) begin
                        state_d   = S_LOAD;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    word_d     = word_merged;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d    = S_WRITE;
                        s_ready_d  = 1'b0;
                        mem_we_d   = 1'b1;
                        mem_addr_d = base_q + word_idx_q[ADDR_W-1:0];
                        mem_data_d = word_merged;
                    end
                end
            end

            S_WRITE: begin
                checksum_d = checksum_q ^ mem_data_q;
                if (word_idx_q == count_q - (ADDR_W+1)'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    word_idx_d = word_idx_q + (ADDR_W+1)'(1);
                    byte_idx_d = '0;
                    state_d    = S_LOAD;
                    s_ready_d  = 1'b1;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            s_ready_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            s_ready_q  <= s_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.checksum = checksum_q;
endmodule
